// File: rtl/npc_fetch_ctrl_if.sv
// Purpose : bundles the ID->IF branch-resolution inputs and the IF fetch outputs of npc_fetch_ctrl.
// Ports   : if_stall, br_valid, br_type, cmp_out, id_pc, id_imm16, id_index, id_rs (to ctrl);
//           pc, link_addr, redirect, pend (from ctrl); with PC_EXC_EN also exc_req/eret/epc in, adel_if out.
// Modports: master = pipeline/testbench side, slave = npc_fetch_ctrl side.
interface npc_fetch_ctrl_if;
    logic        if_stall;
    logic        br_valid;
    logic [1:0]  br_type;
    logic        cmp_out;
    logic [31:0] id_pc;
    logic [15:0] id_imm16;
    logic [25:0] id_index;
    logic [31:0] id_rs;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        redirect;
    logic        pend;
`ifdef PC_EXC_EN
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        adel_if;

    modport master (
        output if_stall, br_valid, br_type, cmp_out, id_pc, id_imm16, id_index, id_rs,
               exc_req, eret, epc,
        input  pc, link_addr, redirect, pend, adel_if
    );
    modport slave (
        input  if_stall, br_valid, br_type, cmp_out, id_pc, id_imm16, id_index, id_rs,
               exc_req, eret, epc,
        output pc, link_addr, redirect, pend, adel_if
    );
`else
    modport master (
        output if_stall, br_valid, br_type, cmp_out, id_pc, id_imm16, id_index, id_rs,
        input  pc, link_addr, redirect, pend
    );
    modport slave (
        input  if_stall, br_valid, br_type, cmp_out, id_pc, id_imm16, id_index, id_rs,
        output pc, link_addr, redirect, pend
    );
`endif
endinterface

// File: rtl/npc_fetch_ctrl.sv
// Purpose : IF-stage next-PC generator and PC register with one delay slot; buffers a redirect
//           resolved while IF is frozen. Optional macro PC_EXC_EN adds exception entry / eret / AdEL.
// Ports   : clk, reset (sync, active-high), bus (npc_fetch_ctrl_if.slave).
// Latency : redirect target is loaded into pc on the same edge it is resolved (0 extra cycles) unless
//           if_stall is high, in which case it is applied on the first unstalled edge.
// Backpressure: if_stall holds pc; a second take while a redirect is pending is dropped.
module npc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    npc_fetch_ctrl_if.slave   bus
);
    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_tgt;
    logic        take;
    logic [31:0] target;
    logic [31:0] seq_pc;

    // Branch decode: type 0 with br_valid is treated as "no branch".
    assign take = bus.br_valid &
                  ((bus.br_type == 2'd2) | (bus.br_type == 2'd3) |
                   ((bus.br_type == 2'd1) & bus.cmp_out));

    assign seq_pc = pc_q + 32'd4;

    always_comb begin
        logic [31:0] id_pc4;
        id_pc4 = bus.id_pc + 32'd4;
        target = 32'h0;
        case (bus.br_type)
            2'd1:    target = id_pc4 + {{14{bus.id_imm16[15]}}, bus.id_imm16, 2'b00};
            2'd2:    target = {id_pc4[31:28], bus.id_index, 2'b00};
            2'd3:    target = bus.id_rs;
            default: target = 32'h0;
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.link_addr = bus.id_pc + 32'd8;
    assign bus.pend      = (state == PEND);

`ifdef PC_EXC_EN
    logic adel_q;
    logic exc_override;
    assign exc_override = bus.exc_req | bus.eret;
    assign bus.adel_if  = adel_q;
`else
    logic exc_override;
    assign exc_override = 1'b0;
`endif

    // High only in the cycle whose edge loads a branch/jump target into pc.
    assign bus.redirect = !reset && !exc_override && !bus.if_stall &&
                          ((state == RUN && take) || state == PEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            pend_tgt <= 32'h0;
`ifdef PC_EXC_EN
            adel_q   <= 1'b0;
        end else if (bus.exc_req) begin
            state    <= RUN;
            pc_q     <= EXC_VEC;
            adel_q   <= (EXC_VEC[1:0] != 2'b00);
        end else if (bus.eret) begin
            state    <= RUN;
            pc_q     <= bus.epc;
            adel_q   <= (bus.epc[1:0] != 2'b00);
`endif
        end else begin
            case (state)
                RUN: begin
                    if (take && !bus.if_stall) begin
                        pc_q <= target;
`ifdef PC_EXC_EN
                        adel_q <= (target[1:0] != 2'b00);
`endif
                    end else if (take) begin
                        pend_tgt <= target;
                        state    <= PEND;
                    end else if (!bus.if_stall) begin
                        pc_q <= seq_pc;
`ifdef PC_EXC_EN
                        adel_q <= (seq_pc[1:0] != 2'b00);
`endif
                    end
                end
                PEND: begin
                    // Any take seen here is a protocol violation by ID and is ignored.
                    if (!bus.if_stall) begin
                        pc_q  <= pend_tgt;
                        state <= RUN;
`ifdef PC_EXC_EN
                        adel_q <= (pend_tgt[1:0] != 2'b00);
`endif
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_npc_fetch_ctrl.sv
module tb_npc_fetch_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   nerr = 0;
    int   nchk = 0;

    always #5 clk = ~clk;

    npc_fetch_ctrl_if bus ();

    npc_fetch_ctrl #(
        .RESET_PC (32'h0000_3000),
        .EXC_VEC  (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_br();
        bus.br_valid = 1'b0;
        bus.br_type  = 2'd0;
        bus.cmp_out  = 1'b0;
        bus.id_pc    = 32'h0;
        bus.id_imm16 = 16'h0;
        bus.id_index = 26'h0;
        bus.id_rs    = 32'h0;
    endtask

    task automatic set_br(input logic [1:0] t, input logic c, input logic [31:0] ipc,
                          input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
        bus.br_valid = 1'b1;
        bus.br_type  = t;
        bus.cmp_out  = c;
        bus.id_pc    = ipc;
        bus.id_imm16 = imm;
        bus.id_index = idx;
        bus.id_rs    = rs;
    endtask

    initial begin
        reset = 1'b1;
        bus.if_stall = 1'b0;
        clr_br();
`ifdef PC_EXC_EN
        bus.exc_req = 1'b0;
        bus.eret    = 1'b0;
        bus.epc     = 32'h0;
`endif
        // Reset held two cycles.
        step();
        step();
        chk("rst_pc", bus.pc, 32'h0000_3000);
        chk("rst_pend", {31'b0, bus.pend}, 32'd0);
        chk("rst_redir", {31'b0, bus.redirect}, 32'd0);
`ifdef PC_EXC_EN
        chk("rst_adel", {31'b0, bus.adel_if}, 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("run_redir", {31'b0, bus.redirect}, 32'd0);
        step(); chk("seq1", bus.pc, 32'h0000_3004);
        step(); chk("seq2", bus.pc, 32'h0000_3008);
        step(); chk("seq3", bus.pc, 32'h0000_300C);
        step(); chk("seq4", bus.pc, 32'h0000_3010);

        // beq taken, backward offset -2 words: 300C+4-8 = 3008.
        set_br(2'd1, 1'b1, 32'h0000_300C, 16'hFFFE, 26'h0, 32'h0);
        #1;
        chk("beq_redir", {31'b0, bus.redirect}, 32'd1);
        chk("beq_link", bus.link_addr, 32'h0000_3014);
        step();
        chk("beq_pc", bus.pc, 32'h0000_3008);
        clr_br();
        #1;
        chk("beq_redir_off", {31'b0, bus.redirect}, 32'd0);

        // jr under a 3-cycle stall.
        set_br(2'd3, 1'b0, 32'h0000_3004, 16'h0, 26'h0, 32'h0000_3400);
        bus.if_stall = 1'b1;
        #1;
        chk("jr_stall_redir", {31'b0, bus.redirect}, 32'd0);
        step();
        clr_br();
        chk("jr_pend1", {31'b0, bus.pend}, 32'd1);
        chk("jr_hold1", bus.pc, 32'h0000_3008);
        step();
        chk("jr_pend2", {31'b0, bus.pend}, 32'd1);
        chk("jr_hold2", bus.pc, 32'h0000_3008);
        step();
        chk("jr_pend3", {31'b0, bus.pend}, 32'd1);
        chk("jr_hold3", bus.pc, 32'h0000_3008);
        bus.if_stall = 1'b0;
        #1;
        chk("jr_release_redir", {31'b0, bus.redirect}, 32'd1);
        step();
        chk("jr_pc", bus.pc, 32'h0000_3400);
        chk("jr_pend_clr", {31'b0, bus.pend}, 32'd0);
        chk("jr_redir_off", {31'b0, bus.redirect}, 32'd0);
        step();
        chk("jr_seq", bus.pc, 32'h0000_3404);

        // jr to top of address space, then not-taken branch -> pc wraps to 0.
        set_br(2'd3, 1'b0, 32'h0000_3400, 16'h0, 26'h0, 32'hFFFF_FFFC);
        step();
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        set_br(2'd1, 1'b0, 32'hFFFF_FFF8, 16'h0010, 26'h0, 32'h0);
        #1;
        chk("nt_redir", {31'b0, bus.redirect}, 32'd0);
        chk("link_wrap", bus.link_addr, 32'h0000_0000);
        step();
        chk("wrap_pc", bus.pc, 32'h0000_0000);

        // j keeps (id_pc+4)[31:28]: {3, 0x100, 00} = 3000_0400.
        set_br(2'd2, 1'b0, 32'h3000_0010, 16'h0, 26'h000_0100, 32'h0);
        #1;
        chk("j_redir", {31'b0, bus.redirect}, 32'd1);
        chk("j_link", bus.link_addr, 32'h3000_0018);
        step();
        chk("j_pc", bus.pc, 32'h3000_0400);

        // br_valid with type 0 is ignored.
        set_br(2'd0, 1'b1, 32'h3000_0400, 16'h0040, 26'h3FF_FFFF, 32'h1234_5678);
        #1;
        chk("t0_redir", {31'b0, bus.redirect}, 32'd0);
        step();
        chk("t0_pc", bus.pc, 32'h3000_0404);

        // Forward taken branch: 3000_0400+4+0x40 = 3000_0444.
        set_br(2'd1, 1'b1, 32'h3000_0400, 16'h0010, 26'h0, 32'h0);
        step();
        chk("fwd_pc", bus.pc, 32'h3000_0444);

        // jal buffered, then reset while pending.
        set_br(2'd2, 1'b0, 32'h3000_0440, 16'h0, 26'h000_0020, 32'h0);
        bus.if_stall = 1'b1;
        step();
        chk("jal_pend", {31'b0, bus.pend}, 32'd1);
        clr_br();
        bus.if_stall = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_pend_redir", {31'b0, bus.redirect}, 32'd0);
        step();
        chk("rstp_pc", bus.pc, 32'h0000_3000);
        chk("rstp_pend", {31'b0, bus.pend}, 32'd0);
        reset = 1'b0;
        step();
        chk("rstp_seq1", bus.pc, 32'h0000_3004);
        step();
        chk("rstp_seq2", bus.pc, 32'h0000_3008);

        // A take while pending is dropped; the buffered target wins.
        set_br(2'd3, 1'b0, 32'h0000_3004, 16'h0, 26'h0, 32'h0000_5000);
        bus.if_stall = 1'b1;
        step();
        set_br(2'd3, 1'b0, 32'h0000_3008, 16'h0, 26'h0, 32'h0000_6000);
        bus.if_stall = 1'b0;
        step();
        chk("drop_pc", bus.pc, 32'h0000_5000);
        clr_br();
        step();
        chk("drop_seq", bus.pc, 32'h0000_5004);

`ifdef PC_EXC_EN
        // Exception while pending and stalled.
        set_br(2'd3, 1'b0, 32'h0000_5000, 16'h0, 26'h0, 32'h0000_7000);
        bus.if_stall = 1'b1;
        step();
        clr_br();
        chk("exc_pre_pend", {31'b0, bus.pend}, 32'd1);
        bus.exc_req = 1'b1;
        step();
        chk("exc_pc", bus.pc, 32'h0000_4180);
        chk("exc_pend", {31'b0, bus.pend}, 32'd0);
        bus.exc_req = 1'b0;
        bus.if_stall = 1'b0;
        bus.eret = 1'b1;
        bus.epc  = 32'h0000_3010;
        step();
        chk("eret_pc", bus.pc, 32'h0000_3010);
        chk("eret_adel0", {31'b0, bus.adel_if}, 32'd0);
        bus.epc = 32'h0000_3012;
        step();
        chk("eret_pc_mis", bus.pc, 32'h0000_3012);
        chk("eret_adel1", {31'b0, bus.adel_if}, 32'd1);
        bus.exc_req = 1'b1;
        step();
        chk("exc_wins", bus.pc, 32'h0000_4180);
        chk("exc_adel0", {31'b0, bus.adel_if}, 32'd0);
        bus.exc_req = 1'b0;
        bus.eret = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
